clock_divider_bank: RTL and testbench
=====================================

# clock_divider_bank

Multi-channel, fully synchronous clock-enable generator replacing ripple-clock division in the LFSR test fabric. Each of NUM_CH channels produces a one-cycle tick and a 50% square enable at a runtime-programmable integer divisor, all in the single `clk` domain. A free-running binary counter is also provided for the power-of-two taps consumers previously took from a divided-clock vector. Downstream logic uses `tick` as a clock enable, never as a clock.

## Interface

- NUM_CH, 4, number of independent divider channels (1..16)
- DIV_W, 16, divisor width in bits
- CNT_W, 32, free-running counter width
- DIV_RESET, 2, divisor loaded into every channel at reset (must be < 2^DIV_W)

- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- ch_en  in  NUM_CH  per-channel run enable
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  write can be accepted this cycle
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_div  in  DIV_W  new divisor D
- tick  out  NUM_CH  one-cycle pulse every D enabled cycles
- sq  out  NUM_CH  toggles on every tick (period 2D)
- free_cnt  out  CNT_W  increments every cycle, wraps to 0

## Operation

- Reset (rst_n low at a rising edge): all counters 0, divisors = DIV_RESET, pending flags clear, tick = 0, sq = 0, free_cnt = 0. Reset overrides any concurrent write or terminal count.
- Effective divisor: D_eff = 1 when stored D is 0 or 1, else D.
- Channel counter c runs 0..D_eff-1 while ch_en[i] high; terminal count (TC) is c == D_eff-1 on an enabled edge: c <= 0, tick[i] <= 1, sq[i] <= ~sq[i]. Otherwise tick[i] <= 0.
- D_eff = 1: tick stays high continuously, sq toggles every cycle.
- ch_en[i] low: c <= 0, tick[i] <= 0, sq[i] <= 0. Re-enable restarts from c = 0.
- Config: write accepted at an edge with cfg_valid && cfg_ready. cfg_ready = !pending[cfg_ch] (combinational); cfg_ch >= NUM_CH is accepted and discarded.
- Accepted write stores cfg_div in the channel's shadow register and sets pending. Shadow is copied to the active divisor, and pending cleared, at the channel's next TC edge (new period starts with new D), or at the next edge if the channel is disabled. No truncated or stretched period ever appears.
- Write accepted on the same edge as a TC: not applied at that edge; applies at the following TC.
- Second write to a pending channel stalls (cfg_ready low) until the first applies. Writes to other channels are unaffected.
- free_cnt increments unconditionally, wraps 2^CNT_W-1 -> 0.

## Timing

- All outputs registered; no combinational path from inputs to tick/sq/free_cnt.
- First tick: ch_en[i] sampled high at edge k with c = 0 -> tick[i] high in the cycle after edge k+D_eff-1, then every D_eff cycles.
- Divisor change latency: 1 to D_old cycles after acceptance (enabled), 1 cycle (disabled).
- cfg_ready may fall the cycle after acceptance for the same channel; valid must hold until accepted.

## Structure

- Shared package/header: channel-index width derivation, D_eff rule, DIV_RESET default.
- One sub-module `clock_divider_channel` (counter, active/shadow divisor, pending flag, tick/sq regs) instantiated NUM_CH times via generate; top holds config decode, cfg_ready mux, free_cnt.

## Test plan

- Reset then ch_en = 4'b0001, D = 2 -> tick[0] every 2nd cycle, sq[0] period 4, other channels tick = 0, sq = 0.
- Channel 1 at D = 5, write D = 3 mid-period -> current period completes at 5, next periods 3; cfg_ready low for channel 1 until switch.
- Write D = 0 and D = 1 -> tick continuously high, sq toggles every cycle.
- Write landing on the TC edge -> old D used for one more full period; back-to-back write to same channel stalls until applied.
- Deassert ch_en mid-count, reassert -> tick/sq 0 while off, first tick exactly D cycles after re-enable; rst_n low mid-run -> all outputs 0, divisors = DIV_RESET.
- Run CNT_W = 8 for 300 cycles -> free_cnt wraps 255 -> 0; cfg_ch = NUM_CH write accepted with no channel change.

Source files
------------

// File: rtl/clock_divider_bank_pkg.sv
// Shared definitions for the clock-enable divider bank: index width, effective divisor rule, reset default.
package clock_divider_bank_pkg;
  localparam int DIV_RESET_DEF = 2;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Divisors 0 and 1 both mean "tick every cycle"; callers keep DIV_W <= 32.
  function automatic logic [31:0] div_eff(input logic [31:0] d);
    return (d <= 32'd1) ? 32'd1 : d;
  endfunction
endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, active/shadow divisor with deferred switch, tick and square enable.
module clock_divider_channel
  import clock_divider_bank_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pending,
  output logic             tick,
  output logic             sq
);
  logic [DIV_W-1:0] cnt, div_q, shadow, deff;
  logic             tc;

  assign deff = DIV_W'(div_eff(32'(div_q)));
  assign tc   = (cnt == deff - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_q   <= DIV_W'(DIV_RESET);
      shadow  <= DIV_W'(DIV_RESET);
      pending <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      if (!en) begin
        cnt  <= '0;
        tick <= 1'b0;
        sq   <= 1'b0;
      end else if (tc) begin
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
      end
      // Switch only at a period boundary (or immediately when idle) so no period is cut short.
      if (pending && (!en || tc)) begin
        div_q   <= shadow;
        pending <= 1'b0;
      end
      // A write is only accepted while not pending, so it never collides with the switch above.
      if (wr) begin
        shadow  <= wr_div;
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/clock_divider_bank.sv
// Bank of synchronous clock-enable dividers plus a free-running counter, all in the clk domain.
module clock_divider_bank
  import clock_divider_bank_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  DIV_W     = 16,
  parameter int  CNT_W     = 32,
  parameter int  DIV_RESET = DIV_RESET_DEF,
  localparam int CH_W      = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [CNT_W-1:0]  free_cnt
);
  logic [NUM_CH-1:0]      pending, wr;
  logic [(1<<CH_W)-1:0]   pend_pad;
  logic                   accept;

  // Unused index slots read as not-pending, so out-of-range writes are accepted and dropped.
  always_comb begin
    pend_pad = '0;
    pend_pad[NUM_CH-1:0] = pending;
  end

  assign cfg_ready = !pend_pad[cfg_ch];
  assign accept    = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = accept && (cfg_ch == CH_W'(i));

    clock_divider_channel #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[i]),
      .wr      (wr[i]),
      .wr_div  (cfg_div),
      .pending (pending[i]),
      .tick    (tick[i]),
      .sq      (sq[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) free_cnt <= '0;
    else        free_cnt <= free_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomized scoreboard bench: a period-level reference model predicts tick/sq/free_cnt and cfg_ready.
module tb_clock_divider_bank;
  localparam int NCH   = 3;
  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int DRST  = 2;
  localparam int CHW   = 2;
  localparam int NCYC  = 2500;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] ch_en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;
  logic [CW-1:0]  free_cnt;

  clock_divider_bank #(
    .NUM_CH    (NCH),
    .DIV_W     (DW),
    .CNT_W     (CW),
    .DIV_RESET (DRST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq        (sq),
    .free_cnt  (free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: enabled edges elapsed in the current period, tick parity, divisor plus queued divisor.
  int   run   [NCH];
  int   nticks[NCH];
  int   per   [NCH];
  int   nxt   [NCH];
  bit   pend  [NCH];
  bit   etick [NCH];
  int   efree = 0;
  bit   last_acc = 1'b0;
  bit   saw_wrap = 1'b0;

  function automatic int eff(input int d);
    return (d <= 1) ? 1 : d;
  endfunction

  function automatic bit model_ready(input int ch);
    return (ch >= NCH) ? 1'b1 : !pend[ch];
  endfunction

  initial begin
    for (int i = 0; i < NCH; i++) begin
      run[i] = 0; nticks[i] = 0; per[i] = DRST; nxt[i] = DRST; pend[i] = 0; etick[i] = 0;
    end
  end

  always @(posedge clk) begin
    exp_t e;
    bit   acc;
    acc = rst_n && cfg_valid && model_ready(int'(cfg_ch));
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        run[i] = 0; nticks[i] = 0; per[i] = DRST; pend[i] = 0; etick[i] = 0;
      end
      efree = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!ch_en[i]) begin
          run[i] = 0; nticks[i] = 0; etick[i] = 0;
          if (pend[i]) begin per[i] = nxt[i]; pend[i] = 0; end
        end else begin
          run[i]++;
          etick[i] = (run[i] == eff(per[i]));
          if (etick[i]) begin
            run[i] = 0;
            nticks[i]++;
            if (pend[i]) begin per[i] = nxt[i]; pend[i] = 0; end
          end
        end
      end
      if (acc && int'(cfg_ch) < NCH) begin
        nxt[cfg_ch] = int'(cfg_div);
        pend[cfg_ch] = 1'b1;
      end
      if (efree == (1 << CW) - 1) saw_wrap = 1'b1;
      efree = (efree + 1) % (1 << CW);
    end
    last_acc = acc;
    for (int i = 0; i < NCH; i++) begin
      e.tick[i] = etick[i];
      e.sq[i]   = nticks[i][0];
    end
    e.cnt = CW'(efree);
    sb_q.push_back(e);
  end

  // Monitor: outputs are valid every cycle, so pop one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (tick !== e.tick) begin
        errors++;
        $display("FAIL tick at %0t: got %b expected %b", $time, tick, e.tick);
      end
      checks++;
      if (sq !== e.sq) begin
        errors++;
        $display("FAIL sq at %0t: got %b expected %b", $time, sq, e.sq);
      end
      checks++;
      if (free_cnt !== e.cnt) begin
        errors++;
        $display("FAIL free_cnt at %0t: got %0d expected %0d", $time, free_cnt, e.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ch_en = 3'b001;
    repeat (24) @(negedge clk);
    ch_en = 3'b011;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 39) == 0) ch_en[i] = ~ch_en[i];
      // A request that was not taken must be held unchanged.
      if (!(cfg_valid && !last_acc)) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_ch    = CHW'($urandom_range(0, 3));
        cfg_div   = DW'($urandom_range(0, 6));
      end
      #1;
      checks++;
      if (cfg_ready !== model_ready(int'(cfg_ch))) begin
        errors++;
        $display("FAIL cfg_ready at %0t: ch %0d got %b expected %b",
                 $time, cfg_ch, cfg_ready, model_ready(int'(cfg_ch)));
      end
    end
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (!saw_wrap) begin
      errors++;
      $display("FAIL free_cnt_wrap: got no wrap expected wrap 255->0");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
